// File: rtl/bird_physics_if.sv
// Frame-rate control and sprite-state bundle between the bird engine and its environment.
// The engine takes the slave modport; the timing/renderer side takes the master modport.
interface bird_physics_if;
  logic              frame_tick;
  logic              flap;
  logic        [9:0] bird_y;
  logic signed [5:0] bird_vel;
  logic        [1:0] state;
  logic              game_over;
  logic        [1:0] wing;

  modport master (
    output frame_tick, flap,
    input  bird_y, bird_vel, state, game_over, wing
  );

  modport slave (
    input  frame_tick, flap,
    output bird_y, bird_vel, state, game_over, wing
  );
endinterface

// File: rtl/bird_physics.sv
// Per-frame bird game-state engine: flap capture, gravity/velocity integration,
// ceiling/ground clamping, IDLE/PLAY/DEAD sequencing and wing animation.
module bird_physics #(
  parameter int START_Y  = 200,
  parameter int GROUND_Y = 300,
  parameter int BIRD_H   = 16,
  parameter int GRAVITY  = 1,
  parameter int FLAP_V   = 8,
  parameter int VMAX     = 10,
  parameter int ANIM_DIV = 6
) (
  input  logic          Dis_clk,
  input  logic          rst,
  bird_physics_if.slave bif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic        [9:0]  LP_START = 10'(START_Y);
  localparam logic        [9:0]  LP_FLOOR = 10'(GROUND_Y - BIRD_H);
  localparam logic signed [10:0] LP_FLOOR_S = 11'(GROUND_Y - BIRD_H);
  localparam logic signed [6:0]  LP_FLAP  = 7'(-FLAP_V);
  localparam logic signed [6:0]  LP_VMAX  = 7'(VMAX);
  localparam logic signed [6:0]  LP_GRAV  = 7'(GRAVITY);
  localparam logic     [AW-1:0]  LP_ANIM_LAST = AW'(ANIM_DIV - 1);

  state_t            r_state;
  logic        [9:0] r_bird_y;
  logic signed [5:0] r_bird_vel;
  logic              r_game_over;
  logic        [1:0] r_wing;
  logic     [AW-1:0] r_anim;
  logic              r_flap_q;
  logic              r_flap_pend;

  logic              w_flap_edge;
  logic              w_flap;
  logic signed [6:0] w_v_inc;
  logic signed [6:0] w_v_next;
  logic signed [10:0] w_y_next;

  // Velocity/position candidate for a PLAY tick; widened so the sums cannot wrap.
  always_comb begin
    w_flap_edge = bif.flap & ~r_flap_q;
    w_flap      = r_flap_pend | w_flap_edge;
    w_v_inc     = {r_bird_vel[5], r_bird_vel} + LP_GRAV;
    if (w_flap) begin
      w_v_next = LP_FLAP;
    end else if (w_v_inc > LP_VMAX) begin
      w_v_next = LP_VMAX;
    end else begin
      w_v_next = w_v_inc;
    end
    w_y_next = $signed({1'b0, r_bird_y}) + {{4{w_v_next[6]}}, w_v_next};
  end

  // Flap capture, state machine, kinematics and wing animation, all frame-tick driven.
  always_ff @(posedge Dis_clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bird_y    <= LP_START;
      r_bird_vel  <= 6'sd0;
      r_game_over <= 1'b0;
      r_wing      <= 2'd0;
      r_anim      <= '0;
      r_flap_pend <= 1'b0;
      r_flap_q    <= 1'b1;
    end else begin
      r_flap_q <= bif.flap;
      if (bif.frame_tick) begin
        r_flap_pend <= 1'b0;
        // Wing phase advances while alive; frozen once dead.
        if (r_state == S_IDLE || r_state == S_PLAY) begin
          if (r_anim == LP_ANIM_LAST) begin
            r_anim <= '0;
            r_wing <= r_wing + 2'd1;
          end else begin
            r_anim <= r_anim + AW'(1);
          end
        end
        case (r_state)
          S_IDLE: begin
            r_bird_y <= LP_START;
            if (w_flap) begin
              r_state    <= S_PLAY;
              r_bird_vel <= LP_FLAP[5:0];
            end else begin
              r_bird_vel <= 6'sd0;
            end
          end
          S_PLAY: begin
            if (w_y_next[10]) begin
              r_bird_y   <= 10'd0;
              r_bird_vel <= 6'sd0;
            end else if (w_y_next >= LP_FLOOR_S) begin
              r_bird_y    <= LP_FLOOR;
              r_bird_vel  <= 6'sd0;
              r_state     <= S_DEAD;
              r_game_over <= 1'b1;
            end else begin
              r_bird_y   <= w_y_next[9:0];
              r_bird_vel <= w_v_next[5:0];
            end
          end
          S_DEAD: begin
            if (w_flap) begin
              r_state     <= S_IDLE;
              r_bird_y    <= LP_START;
              r_bird_vel  <= 6'sd0;
              r_game_over <= 1'b0;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_bird_y    <= LP_START;
            r_bird_vel  <= 6'sd0;
            r_game_over <= 1'b0;
          end
        endcase
      end else if (w_flap_edge) begin
        r_flap_pend <= 1'b1;
      end
    end
  end

  assign bif.state     = r_state;
  assign bif.bird_y    = r_bird_y;
  assign bif.bird_vel  = r_bird_vel;
  assign bif.game_over = r_game_over;
  assign bif.wing      = r_wing;

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: stimulus pushes hand-computed expectations into a
// scoreboard; a negedge monitor pops and compares after every tick or reset cycle.
module tb_bird_physics;

  typedef struct packed {
    logic [1:0] st;
    logic [9:0] y;
    logic [5:0] v;
    logic       go;
    logic [1:0] wing;
  } obs_t;

  logic Dis_clk = 1'b0;
  logic rst     = 1'b1;
  bird_physics_if bif ();

  bird_physics dut (
    .Dis_clk (Dis_clk),
    .rst     (rst),
    .bif     (bif.slave)
  );

  always #20 Dis_clk = ~Dis_clk;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Wing phase expectation: advances every tick while the expected state is not DEAD.
  int         m_anim  = 0;
  logic [1:0] m_wing  = 2'd0;
  logic [1:0] m_state = 2'd0;

  int ys[24] = '{193, 187, 182, 178, 175, 173, 172, 172, 173, 175, 178, 182,
                 187, 193, 200, 208, 217, 227, 237, 247, 257, 267, 277, 284};
  int vs[24] = '{-7, -6, -5, -4, -3, -2, -1, 0, 1, 2, 3, 4,
                 5, 6, 7, 8, 9, 10, 10, 10, 10, 10, 10, 0};

  task automatic exp_rst();
    m_anim  = 0;
    m_wing  = 2'd0;
    m_state = 2'd0;
    sb.push_back('{2'd0, 10'd200, 6'd0, 1'b0, 2'd0});
  endtask

  task automatic exp_tick(input logic [1:0] st, input int y, input int v, input logic go);
    obs_t e;
    if (m_state != 2'd2) begin
      if (m_anim == 5) begin
        m_anim = 0;
        m_wing = m_wing + 2'd1;
      end else begin
        m_anim = m_anim + 1;
      end
    end
    m_state = st;
    e.st = st; e.y = 10'(y); e.v = 6'(v); e.go = go; e.wing = m_wing;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic t, input logic f, input logic r);
    bif.frame_tick = t;
    bif.flap       = f;
    rst            = r;
    @(posedge Dis_clk);
    #1;
    bif.frame_tick = 1'b0;
    rst            = 1'b0;
  endtask

  task automatic ntick(input logic [1:0] st, input int y, input int v, input logic go);
    exp_tick(st, y, v, go);
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic ftick(input logic [1:0] st, input int y, input int v, input logic go);
    cyc(1'b0, 1'b1, 1'b0);
    exp_tick(st, y, v, go);
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: output update is due in the cycle after a tick or reset.
  logic tick_seen = 1'b0;
  logic rst_seen  = 1'b0;
  logic armed     = 1'b0;
  obs_t last_got;

  always @(posedge Dis_clk) begin
    tick_seen <= bif.frame_tick;
    rst_seen  <= rst;
  end

  always @(negedge Dis_clk) begin
    obs_t got;
    obs_t e;
    got = '{bif.state, bif.bird_y, bif.bird_vel, bif.game_over, bif.wing};
    if (tick_seen || rst_seen) begin
      armed = 1'b1;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: output update with no expectation at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL update @%0t: got st=%0d y=%0d v=%0d go=%0b wing=%0d, expected st=%0d y=%0d v=%0d go=%0b wing=%0d",
                   $time, got.st, got.y, $signed(got.v), got.go, got.wing,
                   e.st, e.y, $signed(e.v), e.go, e.wing);
        end
      end
    end else if (armed) begin
      n_tests++;
      if (got !== last_got) begin
        n_fail++;
        $display("FAIL hold @%0t: outputs changed without tick, got y=%0d v=%0d st=%0d, expected y=%0d v=%0d st=%0d",
                 $time, got.y, $signed(got.v), got.st, last_got.y, $signed(last_got.v), last_got.st);
      end
    end
    last_got = got;
  end

  initial begin
    int y;
    bif.frame_tick = 1'b0;
    bif.flap       = 1'b0;

    // Reset, then 12 idle ticks (wing 1 after 6, 2 after 12).
    exp_rst(); cyc(1'b0, 1'b0, 1'b1);
    exp_rst(); cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) ntick(2'd0, 200, 0, 1'b0);

    // Start, then free fall to the ground through terminal velocity.
    ftick(2'd1, 200, -8, 1'b0);
    for (int i = 0; i < 24; i++)
      ntick((i == 23) ? 2'd2 : 2'd1, ys[i], vs[i], (i == 23));
    ntick(2'd2, 284, 0, 1'b1);
    ntick(2'd2, 284, 0, 1'b1);

    // Restart, then flap every tick up to the ceiling.
    ftick(2'd0, 200, 0, 1'b0);
    ftick(2'd1, 200, -8, 1'b0);
    for (int k = 1; k <= 25; k++) ftick(2'd1, 200 - 8 * k, -8, 1'b0);
    ftick(2'd1, 0, 0, 1'b0);
    ntick(2'd1, 1, 1, 1'b0);

    // Edge coincident with the tick is consumed by it, nothing left over.
    exp_tick(2'd1, 0, 0, 1'b0); cyc(1'b1, 1'b1, 1'b0);
    ntick(2'd1, 1, 1, 1'b0);

    // Fall a bit, then hold flap across three ticks: one flap only.
    y = 1;
    for (int v = 2; v <= 10; v++) begin
      y = y + v;
      ntick(2'd1, y, v, 1'b0);
    end
    ntick(2'd1, 65, 10, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    exp_tick(2'd1, 57, -8, 1'b0); cyc(1'b1, 1'b1, 1'b0);
    exp_tick(2'd1, 50, -7, 1'b0); cyc(1'b1, 1'b1, 1'b0);
    exp_tick(2'd1, 44, -6, 1'b0); cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Reset coincident with a tick mid-PLAY, flap held through release.
    cyc(1'b0, 1'b1, 1'b0);
    exp_rst(); cyc(1'b1, 1'b1, 1'b1);
    exp_tick(2'd0, 200, 0, 1'b0); cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Two edges between ticks count as a single flap.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    exp_tick(2'd1, 200, -8, 1'b0); cyc(1'b1, 1'b0, 1'b0);
    ntick(2'd1, 193, -7, 1'b0);

    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
